// File: rtl/rvm_uart_rx_pkg.sv
// Shared definitions for the UART receive path: FSM state encodings and the
// default bit period (10 ns clock, 3520 ns per bit).
// No logic; imported by rvm_uart_rx.
package rvm_uart_rx_pkg;

  localparam int RVM_UART_CYCLES_PER_BIT = 352;
  localparam int RVM_UART_DATA_BITS      = 8;

  typedef enum logic [1:0] {
    RVM_UART_RX_IDLE  = 2'd0,
    RVM_UART_RX_START = 2'd1,
    RVM_UART_RX_DATA  = 2'd2,
    RVM_UART_RX_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/rvm_uart_rx_sync_2ff.sv
// Generic two-flop synchroniser for asynchronous level inputs (uart rxd, sw, btn).
// Latency: 2 clk cycles from d to q. No backpressure; samples every cycle.
// Ports: clk, reset (async active-high, loads RESET_VAL), d (async in), q (synchronised out).
module rvm_sync_2ff #(
  parameter int   WIDTH     = 1,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= {WIDTH{RESET_VAL}};
      q    <= {WIDTH{RESET_VAL}};
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rvm_uart_rx.sv
// 8N1 UART receiver (LSB first, idle high) into a single-entry holding register.
// Latency: byte valid CYCLES_PER_BIT/2 + 9*CYCLES_PER_BIT + 1 cycles after start-edge detect.
// Backpressure: rx_valid/rx_ready; a byte finishing while the register is full is dropped (overrun).
// Ports: clk, reset (async active-high), uart_rxd (async serial in), rx_data/rx_valid/rx_ready
//        (holding register handshake), rx_busy (not idle), frame_err/overrun (1-cycle pulses).
module rvm_uart_rx
  import rvm_uart_rx_pkg::*;
#(
  parameter int CYCLES_PER_BIT = RVM_UART_CYCLES_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int            CW        = $clog2(CYCLES_PER_BIT);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CYCLES_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CYCLES_PER_BIT - 1);

  // ---------------------------------------------------------------------------
  // Input path: synchroniser, edge register, post-reset arming
  // ---------------------------------------------------------------------------
  logic       rxd_s;
  logic       rxd_prev;
  logic [1:0] settle_cnt;
  logic       armed;
  logic       fall_det;

  rvm_sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (uart_rxd),
    .q     (rxd_s)
  );

  // The synchroniser and edge register reset to "idle high", so a line that is
  // already low when reset releases would otherwise look like a falling edge.
  // Edge detection is only armed once the synchroniser has flushed its reset
  // value and a genuine high level has been seen on the line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxd_prev   <= 1'b1;
      settle_cnt <= 2'd0;
      armed      <= 1'b0;
    end else begin
      rxd_prev <= rxd_s;
      if (settle_cnt != 2'd2) begin
        settle_cnt <= settle_cnt + 2'd1;
      end
      if ((settle_cnt == 2'd2) && rxd_s) begin
        armed <= 1'b1;
      end
    end
  end

  assign fall_det = armed & rxd_prev & ~rxd_s;

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  rx_state_t     state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt;
  logic [7:0]    shift, shift_nxt;
  logic          cnt_zero;
  logic          load_byte;
  logic          ferr_set;
  logic          ovr_set;

  assign cnt_zero = (cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= RVM_UART_RX_IDLE;
      cnt     <= '0;
      bit_idx <= 3'd0;
      shift   <= 8'h00;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_idx_nxt;
      shift   <= shift_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt_zero ? cnt : cnt - CW'(1);
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    load_byte   = 1'b0;
    ferr_set    = 1'b0;
    ovr_set     = 1'b0;

    unique case (state)
      RVM_UART_RX_IDLE: begin
        // Half-period load puts every later sample in the middle of its bit.
        if (fall_det) begin
          state_nxt = RVM_UART_RX_START;
          cnt_nxt   = HALF_LOAD;
        end
      end

      RVM_UART_RX_START: begin
        if (cnt_zero) begin
          if (rxd_s) begin
            state_nxt = RVM_UART_RX_IDLE;
          end else begin
            state_nxt   = RVM_UART_RX_DATA;
            cnt_nxt     = FULL_LOAD;
            bit_idx_nxt = 3'd0;
          end
        end
      end

      RVM_UART_RX_DATA: begin
        if (cnt_zero) begin
          // LSB arrives first, so shifting right leaves bit 0 in shift[0].
          shift_nxt   = {rxd_s, shift[7:1]};
          bit_idx_nxt = bit_idx + 3'd1;
          cnt_nxt     = FULL_LOAD;
          if (bit_idx == 3'd7) begin
            state_nxt = RVM_UART_RX_STOP;
          end
        end
      end

      RVM_UART_RX_STOP: begin
        if (cnt_zero) begin
          state_nxt = RVM_UART_RX_IDLE;
          if (rxd_s) begin
            if (!rx_valid || rx_ready) begin
              load_byte = 1'b1;
            end else begin
              ovr_set = 1'b1;
            end
          end else begin
            ferr_set = 1'b1;
          end
        end
      end

      default: begin
        state_nxt = RVM_UART_RX_IDLE;
      end
    endcase
  end

  assign rx_busy = (state != RVM_UART_RX_IDLE);

  // ---------------------------------------------------------------------------
  // Holding register and error pulses
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr_set;
      overrun   <= ovr_set;
      // A load in the same cycle as a pop wins and keeps rx_valid high.
      if (load_byte) begin
        rx_data  <= shift;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rvm_uart_rx.sv
module tb_rvm_uart_rx;

  localparam int P = 352;
  localparam int H = P / 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       uart_rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun;

  int checks   = 0;
  int failures = 0;

  rvm_uart_rx #(.CYCLES_PER_BIT(P)) dut (
    .clk       (clk),
    .reset     (reset),
    .uart_rxd  (uart_rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rx_busy   (rx_busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Event monitor, sampled on the falling clock edge.
  int         cyc           = 0;
  logic       busy_q        = 1'b0;
  logic       valid_q       = 1'b0;
  int         busy_rise_cnt = 0;
  int         busy_fall_cnt = 0;
  int         busy_rise_cyc = 0;
  int         valid_rise_cyc = 0;
  int         valid_hi_cnt  = 0;
  int         ferr_cnt      = 0;
  int         ovr_cnt       = 0;
  logic [7:0] popq[$];

  always @(negedge clk) begin
    cyc     <= cyc + 1;
    busy_q  <= rx_busy;
    valid_q <= rx_valid;
    if (rx_busy && !busy_q) begin
      busy_rise_cnt <= busy_rise_cnt + 1;
      busy_rise_cyc <= cyc;
    end
    if (!rx_busy && busy_q) busy_fall_cnt <= busy_fall_cnt + 1;
    if (rx_valid && !valid_q) valid_rise_cyc <= cyc;
    if (rx_valid) valid_hi_cnt <= valid_hi_cnt + 1;
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if (overrun) ovr_cnt <= ovr_cnt + 1;
    if (rx_valid && rx_ready) popq.push_back(rx_data);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    uart_rxd = 1'b0;
    wait_cyc(P);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      wait_cyc(P);
    end
    uart_rxd = stop_bit;
    wait_cyc(P);
    uart_rxd = 1'b1;
  endtask

  int         q0, f0, o0, br0, bf0, v0;
  logic [7:0] c3;

  initial begin
    reset    = 1'b1;
    uart_rxd = 1'b1;
    rx_ready = 1'b1;
    wait_cyc(3);

    // Reset state
    chk("reset_rx_data", 32'(rx_data), 32'h00);
    chk("reset_rx_valid", 32'(rx_valid), 32'h0);
    chk("reset_rx_busy", 32'(rx_busy), 32'h0);
    chk("reset_frame_err", 32'(frame_err), 32'h0);
    chk("reset_overrun", 32'(overrun), 32'h0);
    reset = 1'b0;
    wait_cyc(20);

    // 0x55 with rx_ready high
    q0 = popq.size(); f0 = ferr_cnt; o0 = ovr_cnt; v0 = valid_hi_cnt;
    send_frame(8'h55, 1'b1);
    wait_cyc(5);
    chk("b55_count", 32'(popq.size() - q0), 32'd1);
    if (popq.size() > q0) chk("b55_data", 32'(popq[q0]), 32'h55);
    // busy rises at detect+1, valid at detect+3345
    chk("b55_latency", 32'(valid_rise_cyc - busy_rise_cyc), 32'd3344);
    chk("b55_valid_cycles", 32'(valid_hi_cnt - v0), 32'd1);
    chk("b55_ferr", 32'(ferr_cnt - f0), 32'd0);
    chk("b55_ovr", 32'(ovr_cnt - o0), 32'd0);
    chk("b55_busy_idle", 32'(rx_busy), 32'h0);

    // Back-to-back 0xA5, 0x3C
    q0 = popq.size(); br0 = busy_rise_cnt; bf0 = busy_fall_cnt;
    send_frame(8'hA5, 1'b1);
    send_frame(8'h3C, 1'b1);
    wait_cyc(5);
    chk("b2b_count", 32'(popq.size() - q0), 32'd2);
    if (popq.size() > q0 + 1) begin
      chk("b2b_first", 32'(popq[q0]), 32'hA5);
      chk("b2b_second", 32'(popq[q0 + 1]), 32'h3C);
    end
    chk("b2b_busy_rises", 32'(busy_rise_cnt - br0), 32'd2);
    chk("b2b_busy_falls", 32'(busy_fall_cnt - bf0), 32'd2);

    // Overrun: rx_ready low, 0x12 then 0x34
    rx_ready = 1'b0;
    q0 = popq.size(); o0 = ovr_cnt; f0 = ferr_cnt;
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    wait_cyc(5);
    chk("ovr_pulses", 32'(ovr_cnt - o0), 32'd1);
    chk("ovr_ferr", 32'(ferr_cnt - f0), 32'd0);
    chk("ovr_valid_held", 32'(rx_valid), 32'h1);
    chk("ovr_data_kept", 32'(rx_data), 32'h12);
    chk("ovr_no_pop", 32'(popq.size() - q0), 32'd0);
    rx_ready = 1'b1;
    wait_cyc(1);
    chk("ovr_pop_count", 32'(popq.size() - q0), 32'd1);
    if (popq.size() > q0) chk("ovr_pop_data", 32'(popq[q0]), 32'h12);
    chk("ovr_valid_cleared", 32'(rx_valid), 32'h0);

    // Glitch low for 100 cycles: false start
    q0 = popq.size(); f0 = ferr_cnt; o0 = ovr_cnt; br0 = busy_rise_cnt;
    wait_cyc(50);
    uart_rxd = 1'b0;
    wait_cyc(100);
    uart_rxd = 1'b1;
    wait_cyc(300);
    chk("glitch_started", 32'(busy_rise_cnt - br0), 32'd1);
    chk("glitch_idle", 32'(rx_busy), 32'h0);
    chk("glitch_no_valid", 32'(popq.size() - q0), 32'd0);
    chk("glitch_no_ferr", 32'(ferr_cnt - f0), 32'd0);
    chk("glitch_no_ovr", 32'(ovr_cnt - o0), 32'd0);
    send_frame(8'h00, 1'b1);
    wait_cyc(5);
    chk("b00_count", 32'(popq.size() - q0), 32'd1);
    if (popq.size() > q0) chk("b00_data", 32'(popq[q0]), 32'h00);

    // Framing error: 0xFF with low stop bit, then 0x81
    q0 = popq.size(); f0 = ferr_cnt;
    send_frame(8'hFF, 1'b0);
    wait_cyc(P);
    chk("ferr_pulses", 32'(ferr_cnt - f0), 32'd1);
    chk("ferr_no_valid", 32'(popq.size() - q0), 32'd0);
    chk("ferr_idle", 32'(rx_busy), 32'h0);
    send_frame(8'h81, 1'b1);
    wait_cyc(5);
    chk("b81_count", 32'(popq.size() - q0), 32'd1);
    if (popq.size() > q0) chk("b81_data", 32'(popq[q0]), 32'h81);
    chk("b81_ferr_once", 32'(ferr_cnt - f0), 32'd1);
    chk("b81_data_held", 32'(rx_data), 32'h81);

    // Reset during data bit 4 of 0xC3 (that bit is 0, so the line is low)
    c3 = 8'hC3;
    q0 = popq.size(); f0 = ferr_cnt; o0 = ovr_cnt;
    uart_rxd = 1'b0;
    wait_cyc(P);
    for (int i = 0; i < 4; i++) begin
      uart_rxd = c3[i];
      wait_cyc(P);
    end
    uart_rxd = c3[4];
    wait_cyc(H);
    chk("rst_mid_busy_before", 32'(rx_busy), 32'h1);
    reset = 1'b1;
    #1;
    chk("rst_mid_busy", 32'(rx_busy), 32'h0);
    chk("rst_mid_valid", 32'(rx_valid), 32'h0);
    chk("rst_mid_data", 32'(rx_data), 32'h00);
    chk("rst_mid_ferr", 32'(frame_err), 32'h0);
    chk("rst_mid_ovr", 32'(overrun), 32'h0);
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(P - H - 3);
    for (int i = 5; i < 8; i++) begin
      uart_rxd = c3[i];
      wait_cyc(P);
    end
    uart_rxd = 1'b1;
    wait_cyc(P);
    chk("rst_tail_no_valid", 32'(popq.size() - q0), 32'd0);
    chk("rst_tail_no_ferr", 32'(ferr_cnt - f0), 32'd0);
    chk("rst_tail_idle", 32'(rx_busy), 32'h0);
    send_frame(8'h5A, 1'b1);
    wait_cyc(5);
    chk("b5a_count", 32'(popq.size() - q0), 32'd1);
    if (popq.size() > q0) chk("b5a_data", 32'(popq[q0]), 32'h5A);
    chk("b5a_no_ovr", 32'(ovr_cnt - o0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rvm_uart_rx.md
# rvm_uart_rx

UART receiver for the system top level: it deserialises the asynchronous `uart_rxd` pin into bytes for the core's memory-mapped UART peripheral. Format is 8N1, LSB first, idle high. The default bit period matches the system bench's `send_byte` task: 3520 ns per bit at a 10 ns clock, i.e. 352 cycles. Output is a single-entry holding register with a valid/ready handshake, plus error pulses.

## Interface
- `CYCLES_PER_BIT`, default 352: clock cycles per UART bit. Must be ≥ 4.
- `clk` in 1: system clock.
- `reset` in 1: reset is asynchronous and active-high.
- `uart_rxd` in 1: raw serial input, asynchronous to `clk`.
- `rx_data` out 8: received byte, valid while `rx_valid` is high.
- `rx_valid` out 1: holding register full.
- `rx_ready` in 1: consumer accepts `rx_data` on a cycle where `rx_valid && rx_ready`.
- `rx_busy` out 1: high in any state other than IDLE.
- `frame_err` out 1: one-cycle pulse when the stop bit is sampled low.
- `overrun` out 1: one-cycle pulse when a byte is dropped because the holding register is full.

## Operation
- Input path:
  - `uart_rxd` passes through a 2-FF synchroniser; its reset value is 1 (line idle).
  - A third register holds the previous synchronised value, used for falling-edge detection.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - On a synchronised falling edge (previous 1, current 0), go to START.
  - Load the bit counter with `CYCLES_PER_BIT/2 - 1`.
- START, at counter 0:
  - Sample 1: false start, return to IDLE.
  - Sample 0: go to DATA, reload the counter with `CYCLES_PER_BIT - 1`, set bit index to 0.
- DATA, at counter 0:
  - Shift the sample into the MSB of the shift register (shift right), increment the bit index, reload the counter.
  - After the 8th bit, go to STOP.
- STOP, at counter 0, always return to IDLE:
  - Sample 1 and holding register free, or being popped this same cycle: load `rx_data`, set `rx_valid`.
  - Sample 1 and holding register full with `rx_ready` low: pulse `overrun`; drop the new byte and keep the old one.
  - Sample 0: pulse `frame_err`, discard the byte. Because IDLE requires a falling edge, a held-low break line is not re-armed until it returns high.
- Handshake:
  - `rx_valid` clears on the cycle after `rx_valid && rx_ready`.
  - Pop and load in the same cycle leave `rx_valid` high, holding the new byte.
- Counter width is `$clog2(CYCLES_PER_BIT)` and the counter counts down. The bit index is 3 bits.
- Reset mid-frame: the FSM goes to IDLE and the partial byte is lost. A line still low after reset is not treated as a start until a fresh falling edge.

## Timing
- Reset values:
  - Outputs: `rx_data`=0, `rx_valid`=0, `rx_busy`=0, `frame_err`=0, `overrun`=0.
  - Internal: synchroniser and edge registers = 1, counter = 0, FSM = IDLE.
- Let edge detection in IDLE occur at cycle t, with H = `CYCLES_PER_BIT/2` and P = `CYCLES_PER_BIT`:
  - Start sample at t+H.
  - Data bit i sample at t+H+(i+1)·P.
  - Stop sample at t+H+9P.
  - `rx_valid`, `frame_err` or `overrun` asserts at t+H+9P+1.
- Pin-to-detect latency is 3 cycles: two synchroniser stages plus the edge register.
- Defaults: P=352, H=176, so the byte is ready 3345 cycles after detect.
- Back-to-back frames:
  - After the stop-bit mid-sample, about P/2 cycles remain before the next start edge. IDLE must detect it with no dead cycles.
  - `rx_busy` is low only in IDLE.

## Structure
- In `rvm_constants.v`:
  - FSM state encodings `RVM_UART_RX_IDLE/START/DATA/STOP` (2-bit).
  - `RVM_UART_CYCLES_PER_BIT` = 352.
- One sub-module, `rvm_sync_2ff`: a generic 2-flop synchroniser with a reset-value parameter, reusable for `sw`/`btn` inputs.

## Test plan
- Idle line, then send 0x55 with `rx_ready` high → `rx_valid` for 1 cycle at detect+3345, `rx_data`=0x55, no error pulses.
- Send 0xA5 then 0x3C back-to-back with `rx_ready` high → two valid pulses with data 0xA5 then 0x3C; `rx_busy` drops only between frames.
- `rx_ready` low, send 0x12 then 0x34 → `rx_data` stays 0x12; `overrun` pulses once at the second stop sample. Raising `rx_ready` pops 0x12, then `rx_valid`=0.
- Send 0xFF with stop bit driven 0, then line high → `frame_err` pulses once, `rx_valid` stays 0, next byte 0x81 received correctly.
- Glitch `uart_rxd` low for 100 cycles → false start, return to IDLE, no valid or error pulses. Then send 0x00 → `rx_data`=0x00.
- Assert `reset` during data bit 4 of 0xC3 → all outputs 0 and FSM in IDLE immediately. Next full frame 0x5A → `rx_data`=0x5A.
